sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Request-side controller sitting directly upstream of the single-port SRAM macro wrapper; drives its cen_n/gwen/addr/data_in pins and consumes its registered data_out.
- Converts two independent valid/ready request streams (write, read) into one SRAM access per cycle.
- Buffers read returns in a small response FIFO with valid/ready backpressure for octree node-fetch consumers.

Parameters:
- DATA_W, 64, SRAM word width.
- ADDR_W, 10, SRAM address width.
- RSP_DEPTH, 3, response FIFO entries; must be ≥3 for one read per cycle under zero backpressure.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- wr_valid / wr_ready  in / out  1 each  write request handshake.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid / rd_ready  in / out  1 each  read request handshake.
- rd_addr  in  ADDR_W  read address.
- rsp_valid / rsp_ready  out / in  1 each  read response handshake.
- rsp_data  out  DATA_W  read response data, in request order.
- sram_cen_n  out  1  SRAM chip enable, low active.
- sram_gwen  out  1  0 = write, 1 = read.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data_in  out  DATA_W  SRAM write data.
- sram_data_out  in  DATA_W  SRAM read data, valid the cycle after a read issue.

Behaviour:
- Reset, async on rst_n low: FIFO empty, rsp_valid=0, rd_inflight=0, last_grant=READ. Outputs: sram_cen_n=1, sram_gwen=1, sram_addr=0, sram_data_in=0, wr_ready=0, rd_ready=0.
- SRAM pin outputs are combinational from the grant. An idle cycle drives cen_n=1, gwen=1, addr=0, data_in=0.
- Read credit: rd_ok = (fifo_count + rd_inflight) < RSP_DEPTH. Registered terms only; no rsp_ready→rd_ready path.
- Grant, at most one per cycle:
  - Only wr_valid: write.
  - Only rd_valid with rd_ok: read.
  - Both, rd_ok: grant the type opposite last_grant (round-robin).
  - Both, !rd_ok: write.
  - last_grant updates only on a grant.
- wr_ready = write granted; rd_ready = read granted. Ready may depend on valid. Requesters hold valid/payload stable until accepted.
- Write issue: cen_n=0, gwen=0, addr=wr_addr, data_in=wr_data. Fire-and-forget; no response.
- Read issue in cycle N: cen_n=0, gwen=1, addr=rd_addr; rd_inflight←1 at the end of cycle N. In cycle N+1, sram_data_out is pushed into the FIFO at the end of the cycle, and rd_inflight clears unless another read issues.
- Read latency: issue at edge N → rsp_valid high after edge N+2 when the FIFO was empty (rsp_data driven from FIFO head register).
- FIFO: simultaneous push and pop allowed at any count, including full (pop frees the slot). Push while full without pop cannot occur by the credit rule; a sim assertion flags it. Pointers wrap modulo RSP_DEPTH (non-power-of-two supported).
- A read followed by a write to the same address in the next cycle returns old data. This is the SRAM's natural ordering; no forwarding.
- Reset mid-operation: in-flight read and buffered responses are discarded; no response is produced for them.

Optional Feature:
- Macro SRAM_PORT_CTRL_PERF_EN.
- Defined: adds outputs perf_rd_cnt, perf_wr_cnt, perf_stall_cnt, each 32-bit.
  - rd_cnt and wr_cnt increment on read/write issue.
  - stall_cnt increments each cycle rd_valid=1 && !rd_ok.
  - All saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; function otherwise identical.

Decomposition:
- Package sram_ctrl_pkg:
  - grant_e enum {GNT_NONE, GNT_WR, GNT_RD}.
  - Default width localparams (SRAM_DATA_W=64, SRAM_ADDR_W=10).
  - Parameterised struct typedef for read/write request payloads.
- One sub-module: sram_rsp_fifo (parameterised DATA_W/DEPTH, push/pop, count output, rst_n async).

Test Plan:
- Write 0xDEAD_BEEF_0000_0001 @0x005, then read @0x005, rsp_ready=1 → rsp_data=0xDEAD_BEEF_0000_0001 two cycles after read issue.
- Back-to-back reads @0..7 with rsp_ready=1 → rd_ready stays 1 every cycle; 8 responses in address order, no bubbles.
- rsp_ready=0, 5 reads requested → exactly 3 accepted, rd_ready=0 thereafter. Raise rsp_ready → remaining 2 accepted as slots free; all 5 returned in order.
- wr_valid and rd_valid held high together for 6 cycles (FIFO draining) → grants alternate W,R,W,R,W,R starting with write.
- rst_n pulsed low for one cycle after a read issue → rsp_valid=0, sram_cen_n=1 immediately. The stale response is never delivered; the next read returns correct data.
- PERF_EN build: 4 writes, 3 reads, 2 credit-stalled cycles → perf_wr_cnt=4, perf_rd_cnt=3, perf_stall_cnt=2.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and default widths for the SRAM request-side controller.
//   grant_e        : which access (if any) is issued to the SRAM this cycle
//   SRAM_DATA_W    : default SRAM word width
//   SRAM_ADDR_W    : default SRAM address width
//   sram_wr_req_t  : write request payload at default widths
//   sram_rd_req_t  : read request payload at default widths
//   sat_inc32      : saturating 32-bit increment used by the perf counters
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_DATA_W = 64;
    localparam int SRAM_ADDR_W = 10;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } sram_wr_req_t;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
    } sram_rd_req_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram_rsp_fifo
// Small response FIFO holding SRAM read returns until the consumer takes them.
// Depth need not be a power of two; pointers wrap modulo DEPTH.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i         : write push_data_i into the tail at the end of the cycle
//   push_data_i    : data to store
//   pop_i          : consumer takes the head this cycle (ignored when empty)
//   head_data_o    : head entry, straight from the storage register
//   head_valid_o   : FIFO not empty
//   count_o        : number of stored entries
// Push and pop may occur together at any fill level, including full.
// ---------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_valid_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // When full, wptr == rptr: a simultaneous push overwrites the slot being
    // popped, which becomes the new tail once the head advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q <= count_d;
        end
    end

    assign head_data_o  = mem_q[rptr_q];
    assign head_valid_o = (count_q != '0);
    assign count_o      = count_q;

`ifndef SYNTHESIS
    property p_no_overflow;
        @(posedge clk) disable iff (!rst_n)
            !(push_i && !do_pop && (count_q == CNT_W'(DEPTH)));
    endproperty
    assert property (p_no_overflow)
        else $error("sram_rsp_fifo: push into full fifo without pop");
`endif

endmodule

// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl
// Request-side controller for a single-port SRAM macro wrapper. Merges a write
// request stream and a read request stream into at most one SRAM access per
// cycle and buffers read returns in a response FIFO.
//
// Handshakes: every stream uses valid/ready. A transfer happens on a rising
// edge where valid && ready are both high; the source holds valid and payload
// stable until that edge. wr_ready_o/rd_ready_o may depend on the valids.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o      : write request handshake
//   wr_addr_i, wr_data_i       : write payload
//   rd_valid_i/rd_ready_o      : read request handshake
//   rd_addr_i                  : read payload
//   rsp_valid_o/rsp_ready_i    : read response handshake
//   rsp_data_o                 : read data, in request order
//   sram_cen_n_o, sram_gwen_o  : SRAM enable (low active), 0=write / 1=read
//   sram_addr_o, sram_data_in_o: SRAM address and write data
//   sram_data_out_i            : SRAM read data, valid the cycle after issue
//
// Optional: define SRAM_PORT_CTRL_PERF_EN to add saturating 32-bit counters
//   perf_rd_cnt_o, perf_wr_cnt_o, perf_stall_cnt_o.
// ---------------------------------------------------------------------------
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              sram_cen_n_o,
    output logic              sram_gwen_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_data_in_o,
    input  logic [DATA_W-1:0] sram_data_out_i
`ifdef SRAM_PORT_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt_o,
    output logic [31:0]       perf_wr_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } rd_req_t;

    wr_req_t          wr_req;
    rd_req_t          rd_req;
    grant_e           grant;
    grant_e           last_grant_q, last_grant_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             rd_ok;

    assign wr_req.addr = wr_addr_i;
    assign wr_req.data = wr_data_i;
    assign rd_req.addr = rd_addr_i;

    // A read may issue only if its return is guaranteed a FIFO slot. Built
    // from registered state only, so rsp_ready_i never reaches rd_ready_o.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight_q};
    assign rd_ok       = credit_used < (CNT_W + 1)'(RSP_DEPTH);

    // Grant is gated by rst_n so no access or ready is seen while in reset.
    always_comb begin
        grant = GNT_NONE;
        if (rst_n) begin
            if (wr_valid_i && rd_valid_i && rd_ok) begin
                grant = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
            end else if (wr_valid_i) begin
                grant = GNT_WR;
            end else if (rd_valid_i && rd_ok) begin
                grant = GNT_RD;
            end
        end
    end

    always_comb begin
        sram_cen_n_o   = 1'b1;
        sram_gwen_o    = 1'b1;
        sram_addr_o    = '0;
        sram_data_in_o = '0;
        unique case (grant)
            GNT_WR: begin
                sram_cen_n_o   = 1'b0;
                sram_gwen_o    = 1'b0;
                sram_addr_o    = wr_req.addr;
                sram_data_in_o = wr_req.data;
            end
            GNT_RD: begin
                sram_cen_n_o = 1'b0;
                sram_addr_o  = rd_req.addr;
            end
            default: ;
        endcase
    end

    assign wr_ready_o = (grant == GNT_WR);
    assign rd_ready_o = (grant == GNT_RD);

    assign last_grant_d  = (grant != GNT_NONE) ? grant : last_grant_q;
    assign rd_inflight_d = (grant == GNT_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= GNT_RD;
            rd_inflight_q <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // The read issued last cycle has its data on sram_data_out_i now.
    sram_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (rd_inflight_q),
        .push_data_i  (sram_data_out_i),
        .pop_i        (rsp_ready_i),
        .head_data_o  (rsp_data_o),
        .head_valid_o (rsp_valid_o),
        .count_o      (fifo_count)
    );

`ifdef SRAM_PORT_CTRL_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (grant == GNT_RD) begin
                perf_rd_q <= sat_inc32(perf_rd_q);
            end
            if (grant == GNT_WR) begin
                perf_wr_q <= sat_inc32(perf_wr_q);
            end
            if (rd_valid_i && !rd_ok) begin
                perf_stall_q <= sat_inc32(perf_stall_q);
            end
        end
    end

    assign perf_rd_cnt_o    = perf_rd_q;
    assign perf_wr_cnt_o    = perf_wr_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_port_ctrl
// Self-checking bench for sram_port_ctrl with a behavioural SRAM macro model.
// A table of per-cycle vectors covers the basic write/read path; hand-written
// sequences cover back-to-back reads, backpressure, round-robin arbitration,
// mid-operation reset and (with SRAM_PORT_CTRL_PERF_EN) the perf counters.
// ---------------------------------------------------------------------------
module tb_sram_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [9:0]  wr_addr, rd_addr;
    logic [63:0] wr_data;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        sram_cen_n, sram_gwen;
    logic [9:0]  sram_addr;
    logic [63:0] sram_data_in, sram_data_out;
`ifdef SRAM_PORT_CTRL_PERF_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int pops = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc = 0;
    bit mon_en = 0;

    logic [63:0] exp_q[$];
    logic [63:0] ref_mem [1024];
    logic [63:0] sram_mem [1024];

    sram_port_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid_i       (wr_valid),
        .wr_ready_o       (wr_ready),
        .wr_addr_i        (wr_addr),
        .wr_data_i        (wr_data),
        .rd_valid_i       (rd_valid),
        .rd_ready_o       (rd_ready),
        .rd_addr_i        (rd_addr),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .sram_cen_n_o     (sram_cen_n),
        .sram_gwen_o      (sram_gwen),
        .sram_addr_o      (sram_addr),
        .sram_data_in_o   (sram_data_in),
        .sram_data_out_i  (sram_data_out)
`ifdef SRAM_PORT_CTRL_PERF_EN
        ,
        .perf_rd_cnt_o    (perf_rd_cnt),
        .perf_wr_cnt_o    (perf_wr_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural SRAM macro: registered read data, write on gwen=0.
    always @(posedge clk) begin
        if (!sram_cen_n) begin
            if (!sram_gwen) sram_mem[sram_addr] <= sram_data_in;
            else            sram_data_out       <= sram_mem[sram_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Response monitor: scores every response handshake against exp_q.
    always begin
        @(negedge clk);
        #2;
        if (mon_en && rst_n && rsp_valid && rsp_ready) begin
            pops++;
            if (pops == 1) first_pop_cyc = cyc_cnt;
            last_pop_cyc = cyc_cnt;
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else chk("rsp_data", rsp_data, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        rd_valid = 0; rd_addr = '0;
    endtask

    // One request cycle; reports acceptance seen before the rising edge.
    task automatic cyc(input logic wv, input logic [9:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [9:0] ra, input logic rr,
                       output logic wacc, output logic racc);
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rsp_ready = rr;
        #1;
        wacc = wr_ready;
        racc = rd_ready;
        if (wacc) ref_mem[wa] = wd;
        if (racc) exp_q.push_back(ref_mem[ra]);
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        logic wa, ra;
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cyc(0, '0, '0, 0, '0, 1, wa, ra);
            n++;
        end
        cyc(0, '0, '0, 0, '0, 1, wa, ra);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wv;
        logic [9:0]  wa;
        logic [63:0] wd;
        logic        rv;
        logic [9:0]  ra;
        logic        rr;
        logic        e_wrdy;
        logic        e_rrdy;
        logic        e_cen;
        logic        e_gwen;
        logic [9:0]  e_addr;
        logic [63:0] e_din;
        logic        e_rspv;
        logic [63:0] e_rspd;
    } vec_t;

    function automatic vec_t mk(logic wv, logic [9:0] wa, logic [63:0] wd, logic rv,
                                logic [9:0] ra, logic rr, logic ewr, logic err,
                                logic ecen, logic egwen, logic [9:0] eaddr,
                                logic [63:0] edin, logic ersv, logic [63:0] ersd);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
        v.e_wrdy = ewr; v.e_rrdy = err; v.e_cen = ecen; v.e_gwen = egwen;
        v.e_addr = eaddr; v.e_din = edin; v.e_rspv = ersv; v.e_rspd = ersd;
        return v;
    endfunction

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D3 = 64'hFEDC_BA98_7654_3210;

    vec_t vecs[13];

    // ---------------- main sequence ----------------
    initial begin
        logic wacc, racc;
        int idx, wi, ri, n, pops_before;

        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        //          wv wa     wd  rv ra     rr  wrdy rrdy cen gwen addr   din rspv rspd
        vecs[0]  = mk(1, 10'h5, D1, 0, 10'h0, 1,  1,   0,   0,  0,   10'h5, D1, 0,   '0);
        vecs[1]  = mk(0, 10'h0, '0, 1, 10'h5, 1,  0,   1,   0,  1,   10'h5, '0, 0,   '0);
        vecs[2]  = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 0,   '0);
        vecs[3]  = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 1,   D1);
        vecs[4]  = mk(1, 10'h6, D2, 1, 10'h6, 1,  1,   0,   0,  0,   10'h6, D2, 0,   '0);
        vecs[5]  = mk(0, 10'h0, '0, 1, 10'h6, 1,  0,   1,   0,  1,   10'h6, '0, 0,   '0);
        vecs[6]  = mk(1, 10'h6, D3, 0, 10'h0, 1,  1,   0,   0,  0,   10'h6, D3, 0,   '0);
        vecs[7]  = mk(0, 10'h0, '0, 0, 10'h0, 0,  0,   0,   1,  1,   10'h0, '0, 1,   D2);
        vecs[8]  = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 1,   D2);
        vecs[9]  = mk(0, 10'h0, '0, 1, 10'h6, 1,  0,   1,   0,  1,   10'h6, '0, 0,   '0);
        vecs[10] = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 0,   '0);
        vecs[11] = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 1,   D3);
        vecs[12] = mk(0, 10'h0, '0, 0, 10'h0, 1,  0,   0,   1,  1,   10'h0, '0, 0,   '0);

        // Reset: requests are driven during reset and must not be granted.
        rst_n = 1;
        drive_idle();
        rsp_ready = 1;
        #1 rst_n = 0;
        wr_valid = 1; wr_addr = 10'h3; wr_data = 64'h55;
        rd_valid = 1; rd_addr = 10'h3;
        #1;
        chk("rst_cen_n", sram_cen_n, 1);
        chk("rst_gwen", sram_gwen, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_data_in", sram_data_in, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1;

        // Table: write/read path, latency, arbitration tie, read-before-write.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_valid = vecs[i].rv; rd_addr = vecs[i].ra; rsp_ready = vecs[i].rr;
            #1;
            chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].e_wrdy);
            chk($sformatf("v%0d_rd_ready", i), rd_ready, vecs[i].e_rrdy);
            chk($sformatf("v%0d_cen_n", i), sram_cen_n, vecs[i].e_cen);
            chk($sformatf("v%0d_gwen", i), sram_gwen, vecs[i].e_gwen);
            chk($sformatf("v%0d_addr", i), sram_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_data_in", i), sram_data_in, vecs[i].e_din);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_rspv);
            if (vecs[i].e_rspv) chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].e_rspd);
        end
        ref_mem[10'h5] = D1;
        ref_mem[10'h6] = D3;
        mon_en = 1;

        // Back-to-back reads 0..7: ready every cycle, responses without bubbles.
        for (int i = 0; i < 8; i++)
            cyc(1, 10'(i), 64'hA5A5_0000_0000_0000 + 64'(i * 7 + 1), 0, '0, 1, wacc, racc);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, '0, '0, 1, 10'(i), 1, wacc, racc);
            chk("b2b_rd_ready", racc, 1);
        end
        drain("b2b_drain");
        chk("b2b_count", 64'(pops), 64'd8);
        chk("b2b_no_bubble", 64'(last_pop_cyc - first_pop_cyc), 64'd7);

        // Backpressure: only RSP_DEPTH reads accepted while rsp_ready is low.
        pops = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, '0, '0, (idx < 5), 10'(idx), 0, wacc, racc);
            if (racc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_rd_ready_low", racc, 0);
        n = 0;
        while (idx < 5 && n < 30) begin
            cyc(0, '0, '0, 1, 10'(idx), 1, wacc, racc);
            if (racc) idx++;
            n++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd5);
        drain("bp_drain");
        chk("bp_count", 64'(pops), 64'd5);

        // Both requesters held: grants alternate starting with write.
        wi = 0;
        ri = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 10'h100 + 10'(wi), 64'hC0DE_0000_0000_0000 + 64'(wi), 1, 10'(ri), 1, wacc, racc);
            chk($sformatf("rr%0d_wr_ready", i), wacc, (i % 2 == 0));
            chk($sformatf("rr%0d_rd_ready", i), racc, (i % 2 == 1));
            if (wacc) wi++;
            if (racc) ri++;
        end
        drain("rr_drain");

        // Reset with one buffered response and one read in flight.
        pops_before = pops;
        cyc(0, '0, '0, 1, 10'h100, 0, wacc, racc);
        chk("mr_rd1_acc", racc, 1);
        cyc(0, '0, '0, 1, 10'h101, 0, wacc, racc);
        chk("mr_rd2_acc", racc, 1);
        @(negedge clk);
        drive_idle();
        rsp_ready = 0;
        #1;
        chk("mr_pre_rsp_valid", rsp_valid, 1);
        rst_n = 0;
        wr_valid = 1; rd_valid = 1; rd_addr = 10'h101;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_cen_n", sram_cen_n, 1);
        chk("mr_rd_ready", rd_ready, 0);
        chk("mr_wr_ready", wr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) cyc(0, '0, '0, 0, '0, 1, wacc, racc);
        chk("mr_no_stale", rsp_valid, 0);
        chk("mr_no_stale_pops", 64'(pops - pops_before), 64'd0);
        cyc(0, '0, '0, 1, 10'h102, 1, wacc, racc);
        chk("mr_rd3_acc", racc, 1);
        drain("mr_drain");
        chk("mr_pops", 64'(pops - pops_before), 64'd1);

`ifdef SRAM_PORT_CTRL_PERF_EN
        // Perf counters: 4 writes, 3 reads, 2 credit-stalled cycles.
        pulse_reset();
        #1;
        chk("perf_rst_rd", perf_rd_cnt, 0);
        chk("perf_rst_wr", perf_wr_cnt, 0);
        chk("perf_rst_stall", perf_stall_cnt, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 10'h200 + 10'(i), 64'hBEEF_0000 + 64'(i), 0, '0, 0, wacc, racc);
        for (int i = 0; i < 3; i++) cyc(0, '0, '0, 1, 10'h200 + 10'(i), 0, wacc, racc);
        for (int i = 0; i < 2; i++) begin
            cyc(0, '0, '0, 1, 10'h203, 0, wacc, racc);
            chk("perf_stall_rd_ready", racc, 0);
        end
        drain("perf_drain");
        chk("perf_wr", perf_wr_cnt, 4);
        chk("perf_rd", perf_rd_cnt, 3);
        chk("perf_stall", perf_stall_cnt, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
